// File: rtl/mm_reg_bus_bridge.sv
// Bridges single-cycle CPU load/store requests onto split read/write Wishbone strobes.
// Handles byte-lane select, write-data replication, load extension and an ack timeout.
module mm_reg_bus_bridge #(
    parameter int ADDR_BITS      = 5,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sync_reset,
    input  logic                 mem_re,
    input  logic                 mem_we,
    input  logic [ADDR_BITS+1:0] mem_addr,
    input  logic [1:0]           mem_width,
    input  logic                 mem_sign_ext,
    input  logic [31:0]          mem_wdata,
    output logic                 mem_ready,
    output logic                 mem_err,
    output logic [31:0]          mem_rdata,
    output logic                 WB_RD_STB_O,
    output logic [ADDR_BITS-1:0] WB_RD_ADR_O,
    input  logic [31:0]          WB_RD_DAT_I,
    input  logic                 WB_RD_ACK_I,
    output logic                 WB_WR_STB_O,
    output logic                 WB_WR_WE_O,
    output logic [3:0]           WB_WR_SEL_O,
    output logic [ADDR_BITS-1:0] WB_WR_ADR_O,
    output logic [31:0]          WB_WR_DAT_O,
    input  logic                 WB_WR_ACK_I,
    output logic [1:0]           dbg_state
);

    // Handshake: mem_re/mem_we are one-cycle pulses honoured only in IDLE, and each accepted
    // request ends with exactly one mem_ready pulse. Bus STB is a one-cycle pulse; ADR/SEL/DAT
    // stay stable until the matching ACK, which is only looked at while waiting.

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]           tmo_cnt, tmo_cnt_nxt;
    logic [1:0]           lane_q, width_q;
    logic                 sign_q;
    logic                 req, legal, accept_rd, accept_wr;
    logic [3:0]           sel_req;
    logic [31:0]          wdat_req;
    logic                 rd_stb_nxt, wr_stb_nxt, ready_nxt, err_nxt;
    logic [ADDR_BITS-1:0] rd_adr_nxt, wr_adr_nxt;
    logic [3:0]           sel_nxt;
    logic [31:0]          wdat_nxt, rdata_nxt;

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] lane,
                                                input logic [1:0] width, input logic sign);
        logic [31:0] shifted;
        shifted = raw >> {lane, 3'b000};
        case (width)
            2'd0:    extend_load = {{24{sign & shifted[7]}}, shifted[7:0]};
            2'd1:    extend_load = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: extend_load = shifted;
        endcase
    endfunction

    always_comb begin
        req   = mem_re | mem_we;
        legal = (mem_re ^ mem_we) && (mem_width != 2'd3)
                && !(mem_width == 2'd1 && mem_addr[0])
                && !(mem_width == 2'd2 && mem_addr[1:0] != 2'b00);
        accept_rd = (state == IDLE) && !sync_reset && legal && mem_re;
        accept_wr = (state == IDLE) && !sync_reset && legal && mem_we;
        case (mem_width)
            2'd0: begin
                sel_req  = 4'b0001 << mem_addr[1:0];
                wdat_req = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
                sel_req  = 4'b0011 << mem_addr[1:0];
                wdat_req = {2{mem_wdata[15:0]}};
            end
            default: begin
                sel_req  = 4'b1111;
                wdat_req = mem_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sync_reset) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!legal)      state_nxt = RESP;
                        else if (mem_re) state_nxt = RD_WAIT;
                        else             state_nxt = WR_WAIT;
                    end
                end
                RD_WAIT: if (WB_RD_ACK_I || tmo_cnt == TMO_LIMIT) state_nxt = RESP;
                WR_WAIT: if (WB_WR_ACK_I || tmo_cnt == TMO_LIMIT) state_nxt = RESP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs; a stay in a wait state keeps the address phase.
    always_comb begin
        rd_stb_nxt = accept_rd;
        wr_stb_nxt = accept_wr;
        rd_adr_nxt = '0;
        wr_adr_nxt = '0;
        sel_nxt    = '0;
        wdat_nxt   = '0;
        if (accept_rd) begin
            rd_adr_nxt = mem_addr[ADDR_BITS+1:2];
        end else if (state == RD_WAIT && state_nxt == RD_WAIT) begin
            rd_adr_nxt = WB_RD_ADR_O;
        end
        if (accept_wr) begin
            wr_adr_nxt = mem_addr[ADDR_BITS+1:2];
            sel_nxt    = sel_req;
            wdat_nxt   = wdat_req;
        end else if (state == WR_WAIT && state_nxt == WR_WAIT) begin
            wr_adr_nxt = WB_WR_ADR_O;
            sel_nxt    = WB_WR_SEL_O;
            wdat_nxt   = WB_WR_DAT_O;
        end
        ready_nxt = (state_nxt == RESP);
        err_nxt   = ready_nxt && !((state == RD_WAIT && WB_RD_ACK_I)
                                || (state == WR_WAIT && WB_WR_ACK_I));
        rdata_nxt = '0;
        if (state == RD_WAIT && state_nxt == RESP && WB_RD_ACK_I) begin
            rdata_nxt = extend_load(WB_RD_DAT_I, lane_q, width_q, sign_q);
        end
        tmo_cnt_nxt = '0;
        if ((state == RD_WAIT || state == WR_WAIT) && state_nxt == state) begin
            tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt     <= '0;
            lane_q      <= '0;
            width_q     <= '0;
            sign_q      <= 1'b0;
            mem_ready   <= 1'b0;
            mem_err     <= 1'b0;
            mem_rdata   <= '0;
            WB_RD_STB_O <= 1'b0;
            WB_RD_ADR_O <= '0;
            WB_WR_STB_O <= 1'b0;
            WB_WR_WE_O  <= 1'b0;
            WB_WR_SEL_O <= '0;
            WB_WR_ADR_O <= '0;
            WB_WR_DAT_O <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
            if (accept_rd) begin
                lane_q  <= mem_addr[1:0];
                width_q <= mem_width;
                sign_q  <= mem_sign_ext;
            end
            mem_ready   <= ready_nxt;
            mem_err     <= err_nxt;
            mem_rdata   <= rdata_nxt;
            WB_RD_STB_O <= rd_stb_nxt;
            WB_RD_ADR_O <= rd_adr_nxt;
            WB_WR_STB_O <= wr_stb_nxt;
            WB_WR_WE_O  <= wr_stb_nxt;
            WB_WR_SEL_O <= sel_nxt;
            WB_WR_ADR_O <= wr_adr_nxt;
            WB_WR_DAT_O <= wdat_nxt;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mm_reg_bus_bridge.sv
// Bench for mm_reg_bus_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level model of the bridge.
module tb_mm_reg_bus_bridge;
    localparam int AB = 5;
    localparam int T  = 15;

    logic          clk = 1'b0;
    logic          reset_n, sync_reset, mem_re, mem_we, mem_sign_ext;
    logic [AB+1:0] mem_addr;
    logic [1:0]    mem_width;
    logic [31:0]   mem_wdata, mem_rdata, WB_RD_DAT_I, WB_WR_DAT_O;
    logic          mem_ready, mem_err, WB_RD_STB_O, WB_RD_ACK_I;
    logic          WB_WR_STB_O, WB_WR_WE_O, WB_WR_ACK_I;
    logic [AB-1:0] WB_RD_ADR_O, WB_WR_ADR_O;
    logic [3:0]    WB_WR_SEL_O;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // observations from the driver
    int o_ready_cyc, o_ready_n, o_rd_n, o_wr_n, o_we_n, o_stb_cyc;
    logic o_err, o_adr_bad;
    logic [31:0] o_rdata, o_dat;
    logic [AB-1:0] o_rd_adr, o_wr_adr;
    logic [3:0] o_sel;
    // expectations from the model
    int e_ready_cyc, e_rd_n, e_wr_n;
    logic e_legal, e_err;
    logic [31:0] e_rdata, e_dat;
    logic [AB-1:0] e_adr;
    logic [3:0] e_sel;

    always #5 clk = ~clk;

    mm_reg_bus_bridge #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
        .mem_sign_ext(mem_sign_ext), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .WB_RD_STB_O(WB_RD_STB_O), .WB_RD_ADR_O(WB_RD_ADR_O), .WB_RD_DAT_I(WB_RD_DAT_I),
        .WB_RD_ACK_I(WB_RD_ACK_I), .WB_WR_STB_O(WB_WR_STB_O), .WB_WR_WE_O(WB_WR_WE_O),
        .WB_WR_SEL_O(WB_WR_SEL_O), .WB_WR_ADR_O(WB_WR_ADR_O), .WB_WR_DAT_O(WB_WR_DAT_O),
        .WB_WR_ACK_I(WB_WR_ACK_I), .dbg_state(dbg_state)
    );

    function automatic logic [86:0] all_outs();
        return {mem_ready, mem_err, mem_rdata, WB_RD_STB_O, WB_RD_ADR_O, WB_WR_STB_O,
                WB_WR_WE_O, WB_WR_SEL_O, WB_WR_ADR_O, WB_WR_DAT_O, dbg_state};
    endfunction

    // Transaction-level model: legality from alignment, outcome from the ack cycle.
    task automatic model_txn(input logic re, input logic we, input logic [6:0] addr,
                             input logic [1:0] w, input logic s, input logic [31:0] wd,
                             input int ack_cyc, input logic [31:0] rdat);
        int nb, off;
        longint v, mask;
        off = int'(addr) % 4;
        nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        e_legal = (re != we) && (w != 2'd3) && (off % nb == 0);
        e_adr = 5'(addr >> 2);
        e_sel = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e_dat[8*i +: 8] = wd[8*(i % nb) +: 8];
        e_rdata = '0;
        if (!e_legal) begin
            e_ready_cyc = 1; e_err = 1'b1; e_rd_n = 0; e_wr_n = 0;
        end else begin
            e_rd_n = int'(re); e_wr_n = int'(we);
            if (ack_cyc >= 1 && ack_cyc <= T + 1) begin
                e_ready_cyc = ack_cyc + 1; e_err = 1'b0;
                if (re) begin
                    mask = (longint'(1) << (8 * nb)) - 1;
                    v = (longint'(rdat) >> (8 * off)) & mask;
                    if (s && nb < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
                    e_rdata = 32'(v);
                end
            end else begin
                e_ready_cyc = T + 2; e_err = 1'b1;
            end
        end
        exp_q.push_back(e_rdata);
    endtask

    // Drives one request in window 0 and plays the slave for max_cyc further windows.
    task automatic run_txn(input logic re, input logic we, input logic [6:0] addr,
                           input logic [1:0] w, input logic s, input logic [31:0] wd,
                           input int ack_cyc, input logic [31:0] rdat,
                           input logic extra_req, input int max_cyc);
        o_ready_cyc = -1; o_ready_n = 0; o_rd_n = 0; o_wr_n = 0; o_we_n = 0; o_stb_cyc = -1;
        o_err = 1'b0; o_adr_bad = 1'b0; o_rdata = '0; o_dat = '0; o_sel = '0;
        o_rd_adr = '0; o_wr_adr = '0;
        mem_re = re; mem_we = we; mem_addr = addr; mem_width = w;
        mem_sign_ext = s; mem_wdata = wd;
        @(posedge clk); #1;
        mem_re = extra_req; mem_we = 1'b0; mem_addr = 7'($urandom); mem_wdata = $urandom;
        for (int k = 1; k <= max_cyc; k++) begin
            if (k > 1 && !mem_ready && o_ready_n == 0 && o_stb_cyc > 0 &&
                ((o_rd_n > 0 && WB_RD_ADR_O !== o_rd_adr) ||
                 (o_wr_n > 0 && WB_WR_ADR_O !== o_wr_adr))) o_adr_bad = 1'b1;
            if (WB_RD_STB_O) begin o_rd_n++; o_stb_cyc = k; o_rd_adr = WB_RD_ADR_O; end
            if (WB_WR_STB_O) begin
                o_wr_n++; o_stb_cyc = k; o_wr_adr = WB_WR_ADR_O;
                o_sel = WB_WR_SEL_O; o_dat = WB_WR_DAT_O;
            end
            if (WB_WR_WE_O) o_we_n++;
            if (mem_ready) begin
                if (o_ready_n == 0) begin o_ready_cyc = k; o_err = mem_err; o_rdata = mem_rdata; end
                o_ready_n++;
            end
            mem_re = 1'b0;
            WB_RD_ACK_I = re && (k == ack_cyc);
            WB_WR_ACK_I = we && !re && (k == ack_cyc);
            WB_RD_DAT_I = (k == ack_cyc) ? rdat : $urandom;
            @(posedge clk); #1;
        end
        WB_RD_ACK_I = 1'b0; WB_WR_ACK_I = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sync_reset = 1'b0; mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0;
        mem_width = '0; mem_sign_ext = 1'b0; mem_wdata = '0; WB_RD_DAT_I = '0;
        WB_RD_ACK_I = 1'b0; WB_WR_ACK_I = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++; $display("FAIL reset_idle got=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_word_load();
        logic [31:0] got;
        model_txn(1'b1, 1'b0, 7'h10, 2'd2, 1'b0, 32'h0, 2, 32'hDEAD_BEEF);
        got = exp_q.pop_front();
        run_txn(1'b1, 1'b0, 7'h10, 2'd2, 1'b0, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, T + 6);
        checks++;
        if (o_rd_adr !== 5'd4 || o_stb_cyc != 1) begin
            failures++; $display("FAIL word_load_adr got=%0d@%0d exp=4@1", o_rd_adr, o_stb_cyc);
        end
        checks++;
        if (o_ready_cyc != 3 || o_ready_n != 1) begin
            failures++; $display("FAIL word_load_ready got=%0d x%0d exp=3 x1", o_ready_cyc, o_ready_n);
        end
        checks++;
        if (o_rdata !== 32'hDEAD_BEEF || o_rdata !== got || o_err !== 1'b0) begin
            failures++; $display("FAIL word_load_data got=%h err=%b exp=deadbeef err=0", o_rdata, o_err);
        end
    endtask

    task automatic test_byte_store();
        model_txn(1'b0, 1'b1, 7'h0E, 2'd0, 1'b0, 32'h0000_00A5, 2, 32'h0);
        void'(exp_q.pop_front());
        run_txn(1'b0, 1'b1, 7'h0E, 2'd0, 1'b0, 32'h0000_00A5, 2, 32'h0, 1'b0, T + 6);
        checks++;
        if (o_wr_n != 1 || o_we_n != 1 || o_rd_n != 0) begin
            failures++; $display("FAIL byte_store_strobes got=stb%0d we%0d rd%0d exp=1 1 0", o_wr_n, o_we_n, o_rd_n);
        end
        checks++;
        if (o_sel !== 4'b0100 || o_dat !== 32'hA5A5_A5A5 || o_wr_adr !== 5'd3) begin
            failures++; $display("FAIL byte_store_lanes got=sel%b dat%h adr%0d exp=0100 a5a5a5a5 3", o_sel, o_dat, o_wr_adr);
        end
        checks++;
        if (o_ready_cyc != 3 || o_err !== 1'b0 || o_rdata !== 32'h0 || o_adr_bad) begin
            failures++; $display("FAIL byte_store_resp got=%0d err=%b exp=3 err=0", o_ready_cyc, o_err);
        end
    endtask

    task automatic test_half_load();
        run_txn(1'b1, 1'b0, 7'h06, 2'd1, 1'b1, 32'h0, 2, 32'h8001_1234, 1'b0, T + 6);
        checks++;
        if (o_rdata !== 32'hFFFF_8001 || o_ready_cyc != 3) begin
            failures++; $display("FAIL half_signed got=%h exp=ffff8001", o_rdata);
        end
        run_txn(1'b1, 1'b0, 7'h06, 2'd1, 1'b0, 32'h0, 2, 32'h8001_1234, 1'b0, T + 6);
        checks++;
        if (o_rdata !== 32'h0000_8001) begin
            failures++; $display("FAIL half_unsigned got=%h exp=00008001", o_rdata);
        end
        run_txn(1'b1, 1'b0, 7'h13, 2'd0, 1'b1, 32'h0, 2, 32'h7F80_0000, 1'b0, T + 6);
        checks++;
        if (o_rdata !== 32'h0000_007F) begin
            failures++; $display("FAIL byte_lane3_signed got=%h exp=0000007f", o_rdata);
        end
    endtask

    task automatic test_illegal();
        run_txn(1'b1, 1'b0, 7'h05, 2'd2, 1'b0, 32'h0, 1, 32'h1111_1111, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != 1 || o_err !== 1'b1 || o_rd_n != 0 || o_ready_n != 1) begin
            failures++; $display("FAIL misaligned_word got=%0d err=%b stb=%0d exp=1 err=1 stb=0", o_ready_cyc, o_err, o_rd_n);
        end
        run_txn(1'b1, 1'b1, 7'h08, 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != 1 || o_err !== 1'b1 || o_rd_n + o_wr_n != 0) begin
            failures++; $display("FAIL re_and_we got=%0d err=%b stb=%0d exp=1 err=1 stb=0", o_ready_cyc, o_err, o_rd_n + o_wr_n);
        end
        run_txn(1'b0, 1'b1, 7'h00, 2'd3, 1'b0, 32'h0, 0, 32'h0, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != 1 || o_err !== 1'b1 || o_wr_n != 0) begin
            failures++; $display("FAIL width3 got=%0d err=%b stb=%0d exp=1 err=1 stb=0", o_ready_cyc, o_err, o_wr_n);
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 7'h04, 2'd2, 1'b0, 32'h0, 0, 32'h0, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != T + 2 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_adr_bad) begin
            failures++; $display("FAIL timeout_noack got=%0d err=%b rd=%h exp=%0d err=1 rd=0", o_ready_cyc, o_err, o_rdata, T + 2);
        end
        run_txn(1'b1, 1'b0, 7'h04, 2'd2, 1'b0, 32'h0, T + 1, 32'h5555_AAAA, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != T + 2 || o_err !== 1'b0 || o_rdata !== 32'h5555_AAAA) begin
            failures++; $display("FAIL timeout_ack_wins got=%0d err=%b rd=%h exp=%0d err=0 rd=5555aaaa", o_ready_cyc, o_err, o_rdata, T + 2);
        end
        run_txn(1'b0, 1'b1, 7'h04, 2'd2, 1'b0, 32'h1, T + 2, 32'h0, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != T + 2 || o_err !== 1'b1 || o_ready_n != 1) begin
            failures++; $display("FAIL timeout_late_ack got=%0d err=%b n=%0d exp=%0d err=1 n=1", o_ready_cyc, o_err, o_ready_n, T + 2);
        end
    endtask

    task automatic test_sync_reset();
        int ready_seen = 0;
        int stb_seen = 0;
        logic [31:0] got;
        mem_re = 1'b1; mem_we = 1'b0; mem_addr = 7'h08; mem_width = 2'd2; mem_sign_ext = 1'b0;
        @(posedge clk); #1;
        mem_re = 1'b0;
        checks++;
        if (WB_RD_STB_O !== 1'b1) begin
            failures++; $display("FAIL sync_pre_stb got=%b exp=1", WB_RD_STB_O);
        end
        @(posedge clk); #1;
        sync_reset = 1'b1;
        @(posedge clk); #1;
        sync_reset = 1'b0;
        checks++;
        if ({mem_ready, dbg_state, WB_RD_STB_O, WB_RD_ADR_O} !== 9'h0) begin
            failures++; $display("FAIL sync_abort got=%b/%0d/%b/%0d exp=0/0/0/0", mem_ready, dbg_state, WB_RD_STB_O, WB_RD_ADR_O);
        end
        WB_RD_ACK_I = 1'b1; WB_RD_DAT_I = 32'h1234_5678;
        @(posedge clk); #1;
        WB_RD_ACK_I = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_ready) ready_seen++;
            if (WB_RD_STB_O || WB_WR_STB_O) stb_seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (ready_seen != 0 || stb_seen != 0) begin
            failures++; $display("FAIL sync_late_ack got=ready%0d stb%0d exp=0 0", ready_seen, stb_seen);
        end
        model_txn(1'b1, 1'b0, 7'h0C, 2'd2, 1'b0, 32'h0, 2, 32'hCAFE_F00D);
        got = exp_q.pop_front();
        run_txn(1'b1, 1'b0, 7'h0C, 2'd2, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != 3 || o_rdata !== got || o_err !== 1'b0) begin
            failures++; $display("FAIL sync_recover got=%0d %h exp=3 %h", o_ready_cyc, o_rdata, got);
        end
    endtask

    task automatic test_async_reset_mid();
        logic [31:0] got;
        mem_we = 1'b1; mem_re = 1'b0; mem_addr = 7'h1C; mem_width = 2'd2; mem_wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        mem_we = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL async_reset_mid got=%h exp=0", all_outs());
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_txn(1'b1, 1'b0, 7'h21, 2'd0, 1'b1, 32'h0, 3, 32'h0000_9000);
        got = exp_q.pop_front();
        run_txn(1'b1, 1'b0, 7'h21, 2'd0, 1'b1, 32'h0, 3, 32'h0000_9000, 1'b0, T + 6);
        checks++;
        if (o_ready_cyc != 4 || o_rdata !== got || o_rd_adr !== 5'd8) begin
            failures++; $display("FAIL async_recover got=%0d %h adr%0d exp=4 %h adr8", o_ready_cyc, o_rdata, o_rd_adr, got);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [6:0] addr;
        for (int i = 0; i < 6; i++) begin
            addr = 7'($urandom_range(0, 127)) & 7'h7E;
            model_txn(i[0], !i[0], addr, 2'd1, 1'b1, $urandom, i % 3 + 1, 32'hF00F_8421);
            got = exp_q.pop_front();
            run_txn(i[0], !i[0], addr, 2'd1, 1'b1, e_dat, i % 3 + 1, 32'hF00F_8421, 1'b0, e_ready_cyc);
            checks++;
            if (o_ready_cyc != e_ready_cyc || o_rdata !== got || o_err !== 1'b0) begin
                failures++; $display("FAIL b2b%0d got=%0d %h exp=%0d %h", i, o_ready_cyc, o_rdata, e_ready_cyc, got);
            end
        end
    endtask

    task automatic test_random();
        logic re, we, s, extra;
        logic [1:0] w;
        logic [6:0] addr;
        logic [31:0] wd, rdat, got;
        int sel, ack;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            re = (sel <= 5); we = (sel == 0) || (sel > 5);
            w = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) addr = addr & ~7'((1 << int'(w)) - 1);
            s = 1'($urandom); wd = $urandom; rdat = $urandom; extra = 1'($urandom);
            ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, T + 3);
            model_txn(re, we, addr, w, s, wd, ack, rdat);
            got = exp_q.pop_front();
            run_txn(re, we, addr, w, s, wd, ack, rdat, extra, T + 6);
            checks++;
            if (o_ready_cyc != e_ready_cyc || o_ready_n != 1 || o_err !== e_err || o_rdata !== got) begin
                failures++; $display("FAIL rnd%0d_resp got=%0d x%0d err=%b rd=%h exp=%0d x1 err=%b rd=%h",
                                     n, o_ready_cyc, o_ready_n, o_err, o_rdata, e_ready_cyc, e_err, got);
            end
            checks++;
            if (o_rd_n != e_rd_n || o_wr_n != e_wr_n || o_we_n != e_wr_n || o_adr_bad) begin
                failures++; $display("FAIL rnd%0d_strobes got=rd%0d wr%0d we%0d held%b exp=rd%0d wr%0d we%0d",
                                     n, o_rd_n, o_wr_n, o_we_n, !o_adr_bad, e_rd_n, e_wr_n, e_wr_n);
            end
            if (e_legal) begin
                checks++;
                if (o_stb_cyc != 1 || (re ? o_rd_adr : o_wr_adr) !== e_adr ||
                    (we && (o_sel !== e_sel || o_dat !== e_dat))) begin
                    failures++; $display("FAIL rnd%0d_addr got=@%0d adr%0d sel%b dat%h exp=@1 adr%0d sel%b dat%h",
                                         n, o_stb_cyc, re ? o_rd_adr : o_wr_adr, o_sel, o_dat, e_adr, e_sel, e_dat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_half_load();
        test_illegal();
        test_timeout();
        test_sync_reset();
        test_async_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
